// File: rtl/seq_approx_restoring_divider.sv
// Iterative restoring divider: NW-bit dividend / DW-bit divisor -> QW-bit quotient, DW-bit remainder.
// Latency: out_valid rises exactly QW clocks after the accepting edge; one op per QW+2 clocks at best.
// Backpressure: in_ready only in IDLE; the result is held in DONE until out_ready. Optional macro: DIV_APPROX_EN.
//
// With DIV_APPROX_EN defined, cells in rows k < APX_ROWS and columns j < APX_COLS
// use the approximate subtractor cell; otherwise every cell is exact and the
// result equals the true floor quotient/remainder whenever out_ovf is clear.
// The cell equations match the combinational array-divider rows, so accuracy
// and power sweeps stay comparable between the two implementations.

module seq_approx_restoring_divider #(
    parameter int NW       = 16,
    parameter int DW       = 8,
    parameter int APX_ROWS = 2,
    parameter int APX_COLS = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [NW-1:0] in_n,
    input  logic [DW-1:0] in_d,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [NW-DW-1:0] out_q,
    output logic [DW-1:0] out_r,
    output logic          out_ovf
);

    // Quotient width doubles as the iteration count.
    localparam int QW = NW - DW;
    localparam int KW = (QW > 1) ? $clog2(QW) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;

    // Partial remainder, row index, latched operands and quotient bits.
    logic [DW-1:0]   r_reg;
    logic [KW-1:0]   k_reg;
    logic [QW-1:0]   n_lo;
    logic [DW-1:0]   d_reg;
    logic [QW-1:0]   q_reg;
    logic            ovf_reg;

    // Current-row signals.
    logic [DW-1:0]   row_w;
    logic            row_top;
    logic [DW-1:0]   row_diff;
    logic            row_bout;
    logic            row_q;

    logic            accept;
    logic            last_row;

    assign accept   = (state == S_IDLE) && in_valid;
    assign last_row = (k_reg == '0);

    // One array row: shift in the next dividend bit, then ripple-borrow subtract d.
    always_comb begin
        logic bin;
        logic x;
        logic y;
        logic apx;
        row_w    = {r_reg[DW-2:0], n_lo[k_reg]};
        row_top  = r_reg[DW-1];
        row_diff = '0;
        bin      = 1'b0;
        x        = 1'b0;
        y        = 1'b0;
        apx      = 1'b0;
        for (int j = 0; j < DW; j++) begin
            x = row_w[j];
            y = d_reg[j];
`ifdef DIV_APPROX_EN
            apx = (int'(k_reg) < APX_ROWS) && (j < APX_COLS);
`else
            apx = 1'b0;
`endif
            if (apx) begin
                // Approximate cell: no difference output, simplified borrow.
                row_diff[j] = 1'b0;
                bin         = y & ~bin;
            end else begin
                // Exact full-subtractor cell.
                row_diff[j] = x ^ y ^ bin;
                bin         = (~x & y) | (~(x ^ y) & bin);
            end
        end
        row_bout = bin;
        // A set top bit means W really exceeds 2^DW > d, so the subtraction always succeeds.
        row_q    = row_top | ~row_bout;
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (last_row) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State register; reset aborts any op in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath: load operands on accept, then retire one quotient bit per RUN clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_reg   <= '0;
            k_reg   <= '0;
            n_lo    <= '0;
            d_reg   <= '0;
            q_reg   <= '0;
            ovf_reg <= 1'b0;
        end else if (accept) begin
            r_reg   <= in_n[NW-1:QW];
            k_reg   <= KW'(QW - 1);
            n_lo    <= in_n[QW-1:0];
            d_reg   <= in_d;
            q_reg   <= '0;
            ovf_reg <= (in_n[NW-1:QW] >= in_d);
        end else if (state == S_RUN) begin
            r_reg        <= row_q ? row_diff : row_w;
            q_reg[k_reg] <= row_q;
            if (!last_row) begin
                k_reg <= k_reg - 1'b1;
            end
        end
    end

    // Registers are frozen outside RUN, so the result is stable throughout DONE.
    assign out_q   = q_reg;
    assign out_r   = r_reg;
    assign out_ovf = ovf_reg;

endmodule

// File: tb/tb_seq_approx_restoring_divider.sv
// Bench for seq_approx_restoring_divider: table vectors, hold/backpressure, mid-run reset, random sweep.
// Expected results come from constants or integer division and pass through a scoreboard queue.
// Outputs are sampled #1 after the rising edge or on the falling edge.
module tb_seq_approx_restoring_divider;

    localparam int NW = 16;
    localparam int DW = 8;
    localparam int QW = NW - DW;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [NW-1:0] in_n;
    logic [DW-1:0] in_d;
    logic          out_valid;
    logic          out_ready;
    logic [QW-1:0] out_q;
    logic [DW-1:0] out_r;
    logic          out_ovf;

    typedef struct {
        logic [NW-1:0] n;
        logic [DW-1:0] d;
        logic [QW-1:0] q;
        logic [DW-1:0] r;
        logic          ovf;
        logic          chk_q;
        logic          chk_r;
    } vec_t;

    vec_t vt[$];
    vec_t sb[$];

    int total = 0;
    int bad   = 0;

    seq_approx_restoring_divider #(
        .NW(NW), .DW(DW), .APX_ROWS(2), .APX_COLS(8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_n      (in_n),
        .in_d      (in_d),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_q     (out_q),
        .out_r     (out_r),
        .out_ovf   (out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [NW-1:0] n, input logic [DW-1:0] d,
                                input logic [QW-1:0] q, input logic [DW-1:0] r,
                                input logic ovf, input logic cq, input logic cr);
        vec_t v;
        v.n = n; v.d = d; v.q = q; v.r = r; v.ovf = ovf; v.chk_q = cq; v.chk_r = cr;
        return v;
    endfunction

    // Scoreboard: compare each delivered result against the oldest expected record.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_output", 32'd1, 32'd0);
            end else begin
                vec_t e;
                e = sb.pop_front();
                check("ovf", {31'd0, out_ovf}, {31'd0, e.ovf});
                if (e.chk_q) check("quot", {24'd0, out_q}, {24'd0, e.q});
                if (e.chk_r) check("rem", {24'd0, out_r}, {24'd0, e.r});
            end
        end
    end

    // Issue one op from an idle DUT, check latency, optionally stall, then hand the result off.
    task automatic do_op(input vec_t v, input int hold);
        int lat;
        logic [QW-1:0] sq;
        logic [DW-1:0] sr;
        int unstable;
        int busy;
        sb.push_back(v);
        in_n     = v.n;
        in_d     = v.d;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", lat, QW);
        if (hold > 0) begin
            sq = out_q;
            sr = out_r;
            unstable = 0;
            busy = 0;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk);
                #1;
                if (!out_valid || out_q !== sq || out_r !== sr) unstable++;
                if (in_ready) busy++;
            end
            check("hold_stable", unstable, 0);
            check("hold_in_ready", busy, 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("post_hs_out_valid", {31'd0, out_valid}, 32'd0);
        check("post_hs_in_ready", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        vec_t v;
        int stray;
        vec_t v1000;
        logic [DW-1:0] hi;
        logic [DW-1:0] lo;
        logic [DW-1:0] dd;
        logic [NW-1:0] nn;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_n      = '0;
        in_d      = '0;

`ifdef DIV_APPROX_EN
        v1000 = mk(16'd1000, 8'd7, 8'd143, 8'd0, 1'b0, 1'b1, 1'b1);
        vt.push_back(v1000);
        vt.push_back(mk(16'h0700, 8'd7,   8'h00, 8'h00, 1'b1, 1'b0, 1'b0));
        vt.push_back(mk(16'd255,  8'd1,   8'd255, 8'd0, 1'b0, 1'b1, 1'b1));
`else
        v1000 = mk(16'd1000, 8'd7, 8'd142, 8'd6, 1'b0, 1'b1, 1'b1);
        vt.push_back(v1000);
        vt.push_back(mk(16'h1234, 8'd0,   8'hFF,  8'h00, 1'b1, 1'b1, 1'b0));
        vt.push_back(mk(16'h0700, 8'd7,   8'h00,  8'h00, 1'b1, 1'b0, 1'b0));
        vt.push_back(mk(16'd255,  8'd1,   8'd255, 8'd0,  1'b0, 1'b1, 1'b1));
        vt.push_back(mk(16'd0,    8'd5,   8'd0,   8'd0,  1'b0, 1'b1, 1'b1));
        vt.push_back(mk(16'd65279, 8'd255, 8'd255, 8'd254, 1'b0, 1'b1, 1'b1));
        vt.push_back(mk(16'd100,  8'd200, 8'd0,   8'd100, 1'b0, 1'b1, 1'b1));
        vt.push_back(mk(16'h7FFF, 8'h80,  8'd255, 8'd127, 1'b0, 1'b1, 1'b1));
        vt.push_back(mk(16'd12345, 8'd99, 8'd124, 8'd69,  1'b0, 1'b1, 1'b1));
`endif

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_outs", {15'd0, out_ovf, out_q, out_r}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Table vectors.
        for (int i = 0; i < vt.size(); i++) begin
            do_op(vt[i], 0);
        end

        // Consumer stalls five clocks in DONE, then the next op starts on the first IDLE clock.
        do_op(v1000, 5);
        do_op(vt[vt.size() - 1], 0);

        // Reset asserted with row k=4 pending; the aborted op must never appear.
        in_n     = 16'h0155;
        in_d     = 8'd9;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_outs", {15'd0, out_ovf, out_q, out_r}, 32'd0);
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        stray = 0;
        for (int i = 0; i < 2 * QW; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) stray++;
            if (!in_ready) stray++;
        end
        check("aborted_op_silent", stray, 0);
        do_op(mk(16'd255, 8'd1, 8'd255, 8'd0, 1'b0, 1'b1, 1'b1), 0);

`ifndef DIV_APPROX_EN
        // Random non-overflow sweep against integer division.
        for (int i = 0; i < 2000; i++) begin
            dd = DW'($urandom_range(1, 255));
            hi = DW'($urandom_range(0, int'(dd) - 1));
            lo = DW'($urandom_range(0, 255));
            nn = {hi, lo};
            v  = mk(nn, dd, QW'(nn / dd), DW'(nn % dd), 1'b0, 1'b1, 1'b1);
            do_op(v, 0);
        end
`endif

        check("scoreboard_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
